rf_dump: RTL and testbench
==========================

# rf_dump

Debug/maintenance master for the 32×32 register file: walks all register addresses and either streams each register's contents out over a valid/ready port (dump) or writes zero to every writable register (clear). Attaches to one register-file read port (address out, data back combinationally) and to the write port. Used by the board-level debug path and by benches to snapshot or scrub architectural state without the CPU core.

## Interface
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register address width (2^ADDR_WIDTH registers)

- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- start_dump  in  1  request a dump; sampled only in IDLE
- start_clear  in  1  request a clear; sampled only in IDLE
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at end of dump or clear
- rf_raddr  out  ADDR_WIDTH  read address to register file
- rf_rdata  in  DATA_WIDTH  combinational read data for rf_raddr (register 0 reads 0)
- rf_wen  out  1  write enable to register file
- rf_waddr  out  ADDR_WIDTH  write address
- rf_wdata  out  DATA_WIDTH  write data (always 0)
- out_valid  out  1  dump beat valid
- out_ready  in  1  downstream accepts beat
- out_addr  out  ADDR_WIDTH  register index of current beat
- out_data  out  DATA_WIDTH  register value of current beat
- out_last  out  1  high on beat with out_addr == 2^ADDR_WIDTH-1

## Operation
- States: IDLE, DUMP, CLEAR, DONE. Registered pointer ptr (ADDR_WIDTH bits); rf_raddr = ptr at all times.
- IDLE: ptr = 0. start_dump high -> DUMP; else start_clear high -> CLEAR (dump wins if both). Starts outside IDLE ignored, not queued.
- Entering DUMP (same edge): out_valid<=1, out_addr<=ptr (0), out_data<=rf_rdata, out_last<=0, ptr<=1.
- DUMP: output register holds beat stable while out_valid && !out_ready. On handshake (out_valid && out_ready): if out_last -> out_valid<=0, state<=DONE; else load next beat {ptr, rf_rdata}, out_last<=(ptr==max), ptr<=ptr+1 (wraps to 0 after max, harmless).
- Data is sampled at load time, not at handshake; block does no coherence with other register-file writers.
- Entering CLEAR: ptr<=1. CLEAR: rf_wen=1, rf_waddr=ptr, rf_wdata=0 (combinational from state/ptr); ptr<=ptr+1 each cycle; write at ptr==max moves to DONE. Register 0 never written.
- DONE: done=1 for exactly one cycle, ptr<=0, next state IDLE. busy high in DUMP, CLEAR, DONE.
- rf_wen is 0 in every state except CLEAR.

## Timing
- Reset values: state IDLE, ptr 0, busy 0, done 0, rf_raddr 0, rf_wen 0, rf_waddr 0, rf_wdata 0, out_valid 0, out_addr 0, out_data 0, out_last 0.
- Dump: start_dump sampled at edge t -> first beat (addr 0) valid from t+1. With out_ready held high: one beat/cycle, beats at t+1..t+32, last handshake at t+32, done at t+33, IDLE at t+34 (accepts new start then).
- Clear: start_clear at edge t -> writes to addr 1..31 in cycles t+1..t+31, done at t+32, IDLE at t+33.
- out_valid never deasserts without a handshake; out_addr/out_data/out_last stable while stalled.
- rst high at any edge (mid-dump, mid-clear, during stall): next cycle all outputs at reset values, no done pulse, in-flight beat dropped.

## Structure
- DATA_WIDTH/ADDR_WIDTH come from the shared register-file defines header; state encodings are local constants of this module.
- Single module; output beat register is inline (no separate skid buffer — one stage suffices since the source is combinational and always ready).

## Test plan
- Preload reg k = 0xA5A50000+k, dump with out_ready=1 -> 32 beats, beat k addr k data 0xA5A50000+k (beat 0 data 0), out_last only on addr 31, done at t+33.
- Dump with out_ready toggling 1,0,0,1,… -> beats in order, no drop/duplicate, outputs stable across stalls.
- Clear after preload -> rf_wen high exactly 31 cycles, addresses 1..31, wdata 0; subsequent dump returns all zeros.
- start_dump and start_clear together in IDLE -> dump runs, no write ever issued; start_clear pulsed mid-dump ignored.
- rst asserted at beat 10 of stalled dump and at write 15 of clear -> next cycle out_valid=0, rf_wen=0, busy=0, no done; new dump then starts from addr 0.

Source files
------------

// File: rtl/rf_dump_pkg.sv
// =============================================================================
// Module      : rf_dump_pkg
// Description : Shared register-file geometry used by the debug dump/clear
//               master and anything else that talks to the 32x32 register file.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package rf_dump_pkg;

    // Register-file geometry
    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_NUM_REGS   = 1 << RF_ADDR_WIDTH;

endpackage : rf_dump_pkg

`default_nettype wire

// File: rtl/rf_dump.sv
// =============================================================================
// Module      : rf_dump
// Description : Debug/maintenance master for the register file. Walks every
//               register address and either streams each value out over a
//               valid/ready port (dump) or writes zero to every writable
//               register (clear).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module rf_dump
    import rf_dump_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_dump,
    input  logic                  start_clear,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    // Walk states; encodings are private to this block
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DUMP  = 2'd1,
        S_CLEAR = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] C_PTR_MAX  = '1;
    localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic                    beat_taken;

    assign beat_taken = out_valid && out_ready;

    // The read port always looks at the walk pointer, so rf_rdata is the
    // value of the register about to be loaded into the beat register.
    assign rf_raddr = ptr;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; dump has priority when both starts arrive together
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_dump) begin
                    state_next = S_DUMP;
                end else if (start_clear) begin
                    state_next = S_CLEAR;
                end
            end
            S_DUMP: begin
                if (beat_taken && out_last) begin
                    state_next = S_DONE;
                end
            end
            S_CLEAR: begin
                if (ptr == C_PTR_MAX) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Status and write-port outputs decoded from state; register 0 is
    // skipped because the clear walk starts the pointer at 1.
    always_comb begin
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        rf_wen   = (state == S_CLEAR);
        rf_waddr = (state == S_CLEAR) ? ptr : '0;
        rf_wdata = '0;
    end

    // Walk pointer and output beat register. A beat is captured from the
    // register file when loaded and then held untouched until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ptr <= '0;
                    if (start_dump) begin
                        out_valid <= 1'b1;
                        out_addr  <= ptr;
                        out_data  <= rf_rdata;
                        out_last  <= 1'b0;
                        ptr       <= C_PTR_ONE;
                    end else if (start_clear) begin
                        ptr <= C_PTR_ONE;
                    end
                end
                S_DUMP: begin
                    if (beat_taken) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                        end else begin
                            out_addr <= ptr;
                            out_data <= rf_rdata;
                            out_last <= (ptr == C_PTR_MAX);
                            // Wraps to 0 after the last load; unused afterwards
                            ptr      <= ptr + C_PTR_ONE;
                        end
                    end
                end
                S_CLEAR: begin
                    ptr <= ptr + C_PTR_ONE;
                end
                S_DONE: begin
                    ptr <= '0;
                end
                default: begin
                    ptr <= '0;
                end
            endcase
        end
    end

endmodule : rf_dump

`default_nettype wire

// File: tb/tb_rf_dump.sv
// =============================================================================
// Module      : tb_rf_dump
// Description : Directed self-checking bench for rf_dump with a behavioural
//               32x32 register file attached to its read and write ports.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_rf_dump;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_dump;
    logic        start_clear;
    logic        busy;
    logic        done;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;

    logic [31:0] regs [32];
    logic        preload;
    int          done_seen = 0;
    int          wen_seen  = 0;
    int          total     = 0;
    int          bad       = 0;

    rf_dump dut (
        .clk         (clk),
        .rst         (rst),
        .start_dump  (start_dump),
        .start_clear (start_clear),
        .busy        (busy),
        .done        (done),
        .rf_raddr    (rf_raddr),
        .rf_rdata    (rf_rdata),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    // Register file model: combinational read, register 0 hardwired to zero
    assign rf_rdata = (rf_raddr == 5'd0) ? 32'h0 : regs[rf_raddr];

    // Register file write port plus bench-driven preload of 0xA5A50000+k
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 32; k++) begin
                regs[k] <= 32'hA5A5_0000 + k;
            end
        end else if (rf_wen && rf_waddr != 5'd0) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    // Event counters for done pulses and write cycles
    always @(posedge clk) begin
        if (done)   done_seen <= done_seen + 1;
        if (rf_wen) wen_seen  <= wen_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pre_val(input int k);
        return (k == 0) ? 32'h0 : (32'hA5A5_0000 + k);
    endfunction

    task automatic do_preload();
        preload = 1'b1;
        tick();
        preload = 1'b0;
    endtask

    // Full dump with out_ready held high; zero selects all-zero expectations
    task automatic dump_full(input bit zero);
        int d0;
        int w0;
        out_ready  = 1'b1;
        start_dump = 1'b1;
        tick();
        start_dump = 1'b0;
        d0 = done_seen;
        w0 = wen_seen;
        for (int k = 0; k < 32; k++) begin
            check("dump_valid", {31'd0, out_valid}, 32'd1);
            check("dump_addr",  {27'd0, out_addr}, k);
            check("dump_data",  out_data, zero ? 32'h0 : pre_val(k));
            check("dump_last",  {31'd0, out_last}, (k == 31) ? 32'd1 : 32'd0);
            check("dump_nodone", {31'd0, done}, 32'd0);
            tick();
        end
        check("dump_done",       {31'd0, done}, 32'd1);
        check("dump_valid_drop", {31'd0, out_valid}, 32'd0);
        check("dump_busy_done",  {31'd0, busy}, 32'd1);
        tick();
        check("dump_done_once", {31'd0, done}, 32'd0);
        check("dump_idle",      {31'd0, busy}, 32'd0);
        check("dump_done_cnt",  done_seen - d0, 32'd1);
        check("dump_no_write",  wen_seen - w0, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          idx;
        int          w0;
        int          d0;
        int          cnt;
        int          at;
        bit          found;
        bit          stalled;
        logic [4:0]  p_addr;
        logic [31:0] p_data;
        logic        p_last;

        rst         = 1'b1;
        start_dump  = 1'b0;
        start_clear = 1'b0;
        out_ready   = 1'b0;
        preload     = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_raddr", {27'd0, rf_raddr}, 32'd0);
        check("rst_wen",   {31'd0, rf_wen}, 32'd0);
        check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_oaddr", {27'd0, out_addr}, 32'd0);
        check("rst_odata", out_data, 32'd0);
        check("rst_olast", {31'd0, out_last}, 32'd0);
        rst = 1'b0;

        // Dump of preloaded file at full rate
        do_preload();
        dump_full(1'b0);

        // Dump with out_ready pattern 1,0,0,1,...; start_clear pulsed mid-dump
        w0 = wen_seen;
        out_ready  = 1'b0;
        start_dump = 1'b1;
        tick();
        start_dump = 1'b0;
        idx = 0;
        stalled = 1'b0;
        p_addr = '0;
        p_data = '0;
        p_last = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) break;
            if (stalled) begin
                check("stall_addr", {27'd0, out_addr}, {27'd0, p_addr});
                check("stall_data", out_data, p_data);
                check("stall_last", {31'd0, out_last}, {31'd0, p_last});
                check("stall_valid", {31'd0, out_valid}, 32'd1);
            end
            out_ready   = (i % 3 == 0);
            start_clear = (i == 20);
            stalled = out_valid && !out_ready;
            p_addr  = out_addr;
            p_data  = out_data;
            p_last  = out_last;
            if (out_valid && out_ready) begin
                check("hs_addr", {27'd0, out_addr}, idx);
                check("hs_data", out_data, pre_val(idx));
                check("hs_last", {31'd0, out_last}, (idx == 31) ? 32'd1 : 32'd0);
                idx++;
            end
            tick();
        end
        start_clear = 1'b0;
        check("stall_done",  {31'd0, done}, 32'd1);
        check("stall_beats", idx, 32'd32);
        check("stall_no_write", wen_seen - w0, 32'd0);
        tick();
        check("stall_idle", {31'd0, busy}, 32'd0);

        // Clear walk after preload
        do_preload();
        start_clear = 1'b1;
        tick();
        start_clear = 1'b0;
        cnt = 0;
        at  = -1;
        for (int c = 0; c < 40; c++) begin
            if (done) begin
                at = c;
                break;
            end
            if (rf_wen) begin
                check("clr_waddr", {27'd0, rf_waddr}, cnt + 1);
                check("clr_wdata", rf_wdata, 32'd0);
                cnt++;
            end
            tick();
        end
        check("clr_count",   cnt, 32'd31);
        check("clr_done_at", at, 32'd31);
        tick();
        check("clr_idle", {31'd0, busy}, 32'd0);
        dump_full(1'b1);

        // Both starts together: dump wins, no write issued
        do_preload();
        w0 = wen_seen;
        out_ready   = 1'b0;
        start_dump  = 1'b1;
        start_clear = 1'b1;
        tick();
        start_dump  = 1'b0;
        start_clear = 1'b0;
        check("both_valid", {31'd0, out_valid}, 32'd1);
        check("both_addr",  {27'd0, out_addr}, 32'd0);
        check("both_wen",   {31'd0, rf_wen}, 32'd0);
        out_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("both_done", {31'd0, found}, 32'd1);
        check("both_no_write", wen_seen - w0, 32'd0);
        tick();

        // Reset during a stall on beat 10 of a dump
        out_ready  = 1'b0;
        start_dump = 1'b1;
        tick();
        start_dump = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (cnt == 10) break;
            out_ready = (i % 2 == 1);
            if (out_valid && out_ready) cnt++;
            tick();
        end
        out_ready = 1'b0;
        check("rd_beat10", {27'd0, out_addr}, 32'd10);
        tick();
        check("rd_stall10", {27'd0, out_addr}, 32'd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d0 = done_seen;
        check("rd_valid", {31'd0, out_valid}, 32'd0);
        check("rd_wen",   {31'd0, rf_wen}, 32'd0);
        check("rd_busy",  {31'd0, busy}, 32'd0);
        check("rd_done",  {31'd0, done}, 32'd0);
        check("rd_oaddr", {27'd0, out_addr}, 32'd0);
        check("rd_odata", out_data, 32'd0);
        check("rd_raddr", {27'd0, rf_raddr}, 32'd0);
        tick();
        tick();
        check("rd_no_done", done_seen - d0, 32'd0);
        dump_full(1'b0);

        // Reset during write 15 of a clear
        found = 1'b0;
        start_clear = 1'b1;
        tick();
        start_clear = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (rf_wen && rf_waddr == 5'd15) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("rc_reach15", {31'd0, found}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d0 = done_seen;
        check("rc_wen",   {31'd0, rf_wen}, 32'd0);
        check("rc_busy",  {31'd0, busy}, 32'd0);
        check("rc_done",  {31'd0, done}, 32'd0);
        check("rc_waddr", {27'd0, rf_waddr}, 32'd0);
        check("rc_reg15", regs[15], 32'h0);
        check("rc_reg16", regs[16], 32'hA5A5_0010);
        tick();
        tick();
        check("rc_no_done", done_seen - d0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rf_dump

`default_nettype wire
